// File: rtl/intpol2_d4_eval_seq_if.sv
// ============================================================================
// Module   : intpol2_d4_eval_seq_if
// Brief    : Coefficient, multiplier and sample-stream bus of the eval sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

interface intpol2_d4_eval_seq_if #(
  parameter int W = 34
);
  logic         coef_valid;
  logic         coef_ready;
  logic [W-1:0] p0;
  logic [W-1:0] p1;
  logic [W-1:0] p2;
  logic [3:0]   log2_l;
  logic         sel_mult;
  logic [W-1:0] xi;
  logic [W-1:0] xi2;
  logic [W-1:0] p1_mul;
  logic [W-1:0] p2_mul;
  logic [W-1:0] mult_data;
  logic [W-1:0] y;
  logic         y_valid;
  logic         y_ready;
  logic         y_last;
  logic         busy;

  modport master (
    input  coef_valid, p0, p1, p2, log2_l, mult_data, y_ready,
    output coef_ready, sel_mult, xi, xi2, p1_mul, p2_mul, y, y_valid, y_last, busy
  );

  modport slave (
    output coef_valid, p0, p1, p2, log2_l, mult_data, y_ready,
    input  coef_ready, sel_mult, xi, xi2, p1_mul, p2_mul, y, y_valid, y_last, busy
  );
endinterface

`default_nettype wire

// File: rtl/intpol2_d4_eval_seq.sv
// ============================================================================
// Module   : intpol2_d4_eval_seq
// Brief    : Sequences the shared multiplier to evaluate p0 + p1*xi + p2*xi^2
// Revision : 1.0
// ============================================================================
`default_nettype none

module intpol2_d4_eval_seq #(
  parameter int DATAPATH_WIDTH = 32,
  parameter int N_BITS         = 2,
  parameter int M_BITS         = 31
) (
  input  wire logic              clk,
  input  wire logic              rstn,
  intpol2_d4_eval_seq_if.master  bus
);

  localparam int W  = DATAPATH_WIDTH + N_BITS;
  localparam int SW = W + 2;
  localparam logic [5:0] c_m_bits = 6'(M_BITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL1 = 2'd1,
    S_MUL2 = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_p0;
  logic [W-1:0]   r_p1;
  logic [W-1:0]   r_p2;
  logic [W-1:0]   r_prod1;
  logic [W-1:0]   r_prod2;
  logic [3:0]     r_l;
  logic [15:0]    r_n;
  logic [31:0]    r_n2;

  logic           w_accept;
  logic           w_y_fire;
  logic           w_last;
  logic [16:0]    w_npts;
  logic [5:0]     w_sh1;
  logic [5:0]     w_sh2;
  logic [SW-1:0]  w_sum;
  logic           w_ovf;
  logic [W-1:0]   w_sat;

  assign w_accept = bus.coef_valid && (r_state == S_IDLE);
  assign w_y_fire = bus.y_ready && (r_state == S_OUT);
  assign w_npts   = 17'd1 << r_l;
  assign w_last   = ({1'b0, r_n} == (w_npts - 17'd1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.coef_valid) w_state_nxt = S_MUL1;
      S_MUL1:  w_state_nxt = S_MUL2;
      S_MUL2:  w_state_nxt = S_OUT;
      S_OUT:   if (bus.y_ready) w_state_nxt = w_last ? S_IDLE : S_MUL1;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // log2_l is 4 bits wide, so the clamp to 15 is inherent in the latch.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_p0    <= '0;
      r_p1    <= '0;
      r_p2    <= '0;
      r_l     <= '0;
      r_n     <= '0;
      r_n2    <= '0;
      r_prod1 <= '0;
      r_prod2 <= '0;
    end else begin
      if (w_accept) begin
        r_p0 <= bus.p0;
        r_p1 <= bus.p1;
        r_p2 <= bus.p2;
        r_l  <= bus.log2_l;
        r_n  <= '0;
        r_n2 <= '0;
      end
      if (r_state == S_MUL1) r_prod1 <= bus.mult_data;
      if (r_state == S_MUL2) r_prod2 <= bus.mult_data;
      // (n+1)^2 = n^2 + 2n + 1 keeps the square multiplier-free.
      if (w_y_fire && !w_last) begin
        r_n  <= r_n + 16'd1;
        r_n2 <= r_n2 + {15'b0, r_n, 1'b0} + 32'd1;
      end
    end
  end

  assign w_sh1   = c_m_bits - {2'b00, r_l};
  assign w_sh2   = c_m_bits - {1'b0, r_l, 1'b0};
  assign bus.xi  = {{(W-16){1'b0}}, r_n}  << w_sh1;
  assign bus.xi2 = {{(W-32){1'b0}}, r_n2} << w_sh2;

  assign w_sum = {{2{r_p0[W-1]}}, r_p0}
               + {{2{r_prod1[W-1]}}, r_prod1}
               + {{2{r_prod2[W-1]}}, r_prod2};

  // Overflow whenever the top three bits disagree; the sign bit picks the rail.
  assign w_ovf = (w_sum[SW-1:W-1] != {3{w_sum[SW-1]}});
  assign w_sat = !w_ovf       ? w_sum[W-1:0] :
                 w_sum[SW-1]  ? {1'b1, {(W-1){1'b0}}} :
                                {1'b0, {(W-1){1'b1}}};

  assign bus.coef_ready = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.sel_mult   = (r_state == S_MUL2);
  assign bus.p1_mul     = r_p1;
  assign bus.p2_mul     = r_p2;
  assign bus.y_valid    = (r_state == S_OUT);
  assign bus.y          = (r_state == S_OUT) ? w_sat : '0;
  assign bus.y_last     = (r_state == S_OUT) && w_last;

endmodule

`default_nettype wire

// File: tb/tb_intpol2_d4_eval_seq.sv
// ============================================================================
// Module   : tb_intpol2_d4_eval_seq
// Brief    : Self-checking bench for the polynomial evaluation sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_intpol2_d4_eval_seq;

  localparam int W = 34;

  typedef struct {
    int                 l;
    logic [W-1:0]       p0;
    logic [W-1:0]       p1;
    logic [W-1:0]       p2;
    logic [3:0][W-1:0]  e;
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [W-1:0] got_y[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  intpol2_d4_eval_seq_if #(.W(W)) bus ();

  intpol2_d4_eval_seq #(
    .DATAPATH_WIDTH(32),
    .N_BITS(2),
    .M_BITS(31)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  // Shared multiplier: full signed product, >> 31, truncated to W bits.
  logic signed [2*W-1:0] m_a, m_b, m_pr;
  always_comb begin
    m_a = bus.sel_mult ? {{W{bus.p2_mul[W-1]}}, bus.p2_mul} : {{W{bus.p1_mul[W-1]}}, bus.p1_mul};
    m_b = bus.sel_mult ? {{W{bus.xi2[W-1]}}, bus.xi2} : {{W{bus.xi[W-1]}}, bus.xi};
    m_pr = m_a * m_b;
    bus.mult_data = m_pr[W+30:31];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: y(n) = p0 + floor(p1*n/2^L) + floor(p2*n^2/4^L), clipped to W bits.
  function automatic logic [W-1:0] ref_y(input int l, input logic [W-1:0] p0, p1, p2, input int n);
    logic signed [79:0] a, b, c, nn, s, lim;
    a  = {{(80-W){p0[W-1]}}, p0};
    b  = {{(80-W){p1[W-1]}}, p1};
    c  = {{(80-W){p2[W-1]}}, p2};
    nn = n;
    s  = a + ((b * nn) >>> l) + ((c * nn * nn) >>> (2 * l));
    lim = 80'sd1 <<< (W - 1);
    if (s > lim - 1) return {1'b0, {(W-1){1'b1}}};
    if (s < -lim)    return {1'b1, {(W-1){1'b0}}};
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] rp();
    logic [63:0] t;
    logic signed [W-1:0] s;
    t = {$urandom, $urandom};
    s = t[W-1:0];
    s = s >>> $urandom_range(0, 3);
    return s;
  endfunction

  function automatic vec_t mk(input int l, input logic [W-1:0] p0, p1, p2, e0, e1, e2, e3);
    vec_t v;
    v.l = l; v.p0 = p0; v.p1 = p1; v.p2 = p2;
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
    return v;
  endfunction

  task automatic run_seg(input int l, input logic [W-1:0] p0, p1, p2,
                         input int stall_idx, input int stall_len, input bit rnd, input int limit);
    int npts;
    int cnt;
    int stall;
    logic [W-1:0] rv;
    longint exi, exi2;
    npts = 1 << l;
    got_y.delete();
    @(negedge clk);
    chk("coef_ready_idle", 64'(bus.coef_ready), 64'd1);
    bus.coef_valid = 1'b1;
    bus.p0 = p0; bus.p1 = p1; bus.p2 = p2;
    bus.log2_l = 4'(l);
    @(negedge clk);
    bus.coef_valid = 1'b0;
    chk("coef_ready_busy", 64'(bus.coef_ready), 64'd0);
    for (int k = 0; k < npts && k < limit; k++) begin
      cnt = 1;
      while (!bus.y_valid && cnt < 20) begin
        if (cnt == 1) begin
          exi  = longint'(k) << (31 - l);
          exi2 = (longint'(k) * k) << (31 - 2 * l);
          chk("xi", 64'(bus.xi), exi);
          chk("xi2", 64'(bus.xi2), exi2);
          chk("sel_mult_mul1", 64'(bus.sel_mult), 64'd0);
        end else if (cnt == 2) begin
          chk("sel_mult_mul2", 64'(bus.sel_mult), 64'd1);
        end
        @(negedge clk);
        cnt++;
      end
      if (!bus.y_valid) begin
        chk("y_valid_timeout", 64'd0, 64'd1);
        return;
      end
      rv = ref_y(l, p0, p1, p2, k);
      chk("latency", 64'(cnt), 64'd3);
      chk("y", 64'(bus.y), 64'(rv));
      chk("y_last", 64'(bus.y_last), 64'(k == npts - 1));
      got_y.push_back(bus.y);
      stall = rnd ? int'($urandom_range(0, 3)) : ((k == stall_idx) ? stall_len : 0);
      repeat (stall) begin
        @(negedge clk);
        chk("stall_valid", 64'(bus.y_valid), 64'd1);
        chk("stall_y", 64'(bus.y), 64'(rv));
        chk("stall_last", 64'(bus.y_last), 64'(k == npts - 1));
        chk("stall_coef_ready", 64'(bus.coef_ready), 64'd0);
      end
      bus.y_ready = 1'b1;
      @(negedge clk);
      bus.y_ready = 1'b0;
    end
    if (limit >= npts) begin
      chk("end_coef_ready", 64'(bus.coef_ready), 64'd1);
      chk("end_busy", 64'(bus.busy), 64'd0);
      chk("end_y_valid", 64'(bus.y_valid), 64'd0);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_coef_ready"}, 64'(bus.coef_ready), 64'd1);
    chk({tag, "_y_valid"}, 64'(bus.y_valid), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_y"}, 64'(bus.y), 64'd0);
    chk({tag, "_y_last"}, 64'(bus.y_last), 64'd0);
    chk({tag, "_sel_mult"}, 64'(bus.sel_mult), 64'd0);
  endtask

  task automatic do_reset(input int cycles);
    rstn = 1'b0;
    repeat (cycles) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.coef_valid = 1'b0;
    bus.p0 = '0; bus.p1 = '0; bus.p2 = '0;
    bus.log2_l = '0;
    bus.y_ready = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    chk("reset_xi", 64'(bus.xi), 64'd0);
    chk("reset_xi2", 64'(bus.xi2), 64'd0);
    rstn = 1'b1;

    vecs[0] = mk(2, 34'h0, 34'h0_8000_0000, 34'h0,
                 34'h0, 34'h0_2000_0000, 34'h0_4000_0000, 34'h0_6000_0000);
    vecs[1] = mk(2, 34'h0, 34'h0, 34'h0_8000_0000,
                 34'h0, 34'h0_0800_0000, 34'h0_2000_0000, 34'h0_4800_0000);
    vecs[2] = mk(2, 34'h0_C000_0000, 34'h0_C000_0000, 34'h0,
                 34'h0_C000_0000, 34'h0_F000_0000, 34'h1_2000_0000, 34'h1_5000_0000);
    vecs[3] = mk(2, 34'h1_8000_0000, 34'h1_8000_0000, 34'h1_8000_0000,
                 34'h1_8000_0000, 34'h1_F800_0000, 34'h1_FFFF_FFFF, 34'h1_FFFF_FFFF);
    vecs[4] = mk(2, 34'h2_8000_0000, 34'h2_8000_0000, 34'h2_8000_0000,
                 34'h2_8000_0000, 34'h2_0800_0000, 34'h2_0000_0000, 34'h2_0000_0000);
    vecs[5] = mk(0, 34'h1234, 34'h0_8000_0000, 34'h0_8000_0000,
                 34'h1234, 34'h0, 34'h0, 34'h0);
    vecs[6] = mk(1, 34'h3_C000_0000, 34'h0_8000_0000, 34'h0_8000_0000,
                 34'h3_C000_0000, 34'h0_2000_0000, 34'h0, 34'h0);

    foreach (vecs[i]) begin
      run_seg(vecs[i].l, vecs[i].p0, vecs[i].p1, vecs[i].p2, -1, 0, 1'b0, 1 << 16);
      chk("table_count", 64'(got_y.size()), 64'(1 << vecs[i].l));
      for (int k = 0; k < (1 << vecs[i].l) && k < got_y.size(); k++)
        chk("table_y", 64'(got_y[k]), 64'(vecs[i].e[k]));
    end

    // Backpressure: 5-cycle stall on the second sample of the linear ramp.
    run_seg(2, 34'h0, 34'h0_8000_0000, 34'h0, 1, 5, 1'b0, 1 << 16);
    chk("bp_count", 64'(got_y.size()), 64'd4);
    if (got_y.size() == 4) chk("bp_y1", 64'(got_y[1]), 64'h2000_0000);

    for (int r = 0; r < 10; r++)
      run_seg(int'($urandom_range(0, 4)), rp(), rp(), rp(), -1, 0, 1'b1, 1 << 16);

    // Reset asserted for two cycles while the first sample is in MUL2.
    @(negedge clk);
    bus.coef_valid = 1'b1;
    bus.p0 = 34'h0_4000_0000; bus.p1 = 34'h0_8000_0000; bus.p2 = 34'h0;
    bus.log2_l = 4'd2;
    @(negedge clk);
    bus.coef_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_mul2", 64'(bus.sel_mult), 64'd1);
    do_reset(2);
    check_idle("midreset");
    bus.y_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_reset_no_y", 64'(bus.y_valid), 64'd0);
    end
    bus.y_ready = 1'b0;

    // L=15: first points only, then abandon the segment through reset.
    run_seg(15, rp(), rp(), rp(), -1, 0, 1'b0, 4);
    do_reset(1);
    check_idle("l15_abort");

    run_seg(1, 34'h0_1000_0000, 34'h0_8000_0000, 34'h0, -1, 0, 1'b0, 1 << 16);
    chk("after_abort_count", 64'(got_y.size()), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
